mem_bus_ctrl: RTL and testbench
===============================

# mem_bus_ctrl

Parametrised memory-map controller between the CPU core and its storage/I/O resources. Decodes a request address into ROM, RAM, or an N-channel I/O port window. Sequences synchronous memory accesses with a configurable wait-state count and a req/ack handshake. Owns the output-port registers and input-port synchronisers, and flags unmapped or illegal accesses as bus faults.

## Interface
- DW, 8, data width
- AW, 8, address width
- ROM_BASE, 'h00, first ROM address
- ROM_SIZE, 128, ROM words
- RAM_BASE, 'h80, first RAM address
- RAM_SIZE, 96, RAM words
- IO_BASE, 'hF0, first I/O port address
- N_PORTS, 16, I/O channels (1..16)
- WAIT_STATES, 1, access cycles before ack (1..7; memory macros have 1-cycle read latency)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- req  in  1  access request, held by master until ack
- we  in  1  1 = write, 0 = read; valid with req
- addr  in  AW  request address; valid with req
- wdata  in  DW  write data; valid with req
- rdata  out  DW  read data; valid in ack cycle, held until next ack
- ack  out  1  one-cycle completion pulse
- fault  out  1  qualifies ack: access was unmapped or illegal
- rom_addr  out  clog2(ROM_SIZE)  ROM macro address
- rom_rdata  in  DW  ROM macro data, 1 cycle after rom_addr
- ram_addr  out  clog2(RAM_SIZE)  RAM macro address
- ram_wdata  out  DW  RAM write data
- ram_we  out  1  RAM write strobe
- ram_rdata  in  DW  RAM macro data, 1 cycle after ram_addr
- port_in  in  N_PORTS*DW  asynchronous input channels, channel k at [k*DW +: DW]
- port_out  out  N_PORTS*DW  registered output channels
- port_wr  out  N_PORTS  one-hot write strobe per channel

## Operation
- Decode (priority order): ROM if ROM_BASE <= addr < ROM_BASE+ROM_SIZE; RAM if RAM_BASE <= addr < RAM_BASE+RAM_SIZE; IO if IO_BASE <= addr < IO_BASE+N_PORTS; otherwise UNMAPPED.
- Offsets: addr minus region base, truncated to the region index width.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: on req, latch we, addr, wdata and decode result; go to ACCESS, with the wait counter at WAIT_STATES-1.
  - ACCESS: decrement the counter; at 0 go to RESP.
  - RESP: ack=1; return to IDLE.
- RAM write: ram_we=1 for exactly the first ACCESS cycle. ram_addr and ram_wdata are held from IDLE capture through RESP.
- ROM/RAM read: rdata is captured from rom_rdata/ram_rdata on entry to RESP.
- IO read: rdata = 2-flop-synchronised port_in channel.
- IO write: port_out channel updated, and port_wr[k] pulses, in the RESP cycle.
- Fault cases (fault=1 with ack, rdata=0, no state change anywhere):
  - write to ROM
  - any UNMAPPED access
- Non-fault acks drive fault=0.
- req is ignored outside IDLE.
- Master must not change addr, we or wdata while req=1 and ack has not been seen.

## Timing
- Reset values: rdata=0, ack=0, fault=0, ram_we=0, rom_addr=0, ram_addr=0, ram_wdata=0, port_out all 0, port_wr=0, synchronisers 0, FSM=IDLE.
- Latency: req first sampled high in IDLE at edge T; ack high during cycle T+WAIT_STATES+1. WAIT_STATES=1 gives 2-cycle latency.
- Back-to-back: IDLE follows RESP. A req still high in the cycle after ack starts a new access. Throughput is one access per WAIT_STATES+2 cycles.
- port_in to rdata: 2 cycles of synchroniser delay before the new value is observable.
- Reset mid-access: the transaction is aborted, no ack is issued, and any RAM write already strobed stands. Master must reissue.
- Addresses near the top of the AW range must not wrap; compare in AW+1 bits.

## Test plan
- Reset: assert reset mid-ACCESS -> ack never pulses; all outputs 0; FSM IDLE on release.
- RAM round trip: write 'hA5 to 'h85, then read 'h85 -> ram_we pulses once with ram_addr=5; read ack at T+2 with rdata='hA5, fault=0.
- ROM read at 'h7F with rom_rdata model = 'h3C -> rom_addr='h7F, rdata='h3C; ROM write to 'h10 -> ack with fault=1, rom/ram untouched.
- IO: write 'h5A to 'hF3 -> port_out[3]='h5A, port_wr=16'h0008 for one cycle; set port_in[3]='hC3, wait 2 cycles, read 'hF3 -> rdata='hC3.
- Unmapped: read 'hE5 and (N_PORTS=4) 'hF7 -> ack, fault=1, rdata=0, port_out unchanged.
- WAIT_STATES=3, req held continuously -> acks exactly every 5 cycles, no missed or duplicate acks.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: decodes CPU bus requests onto ROM, RAM or N_PORTS I/O channels and flags unmapped/illegal accesses as faults.
// Latency: req sampled in IDLE at edge T -> one-cycle ack after edge T+WAIT_STATES; one access per WAIT_STATES+2 cycles.
// Backpressure: master holds req/we/addr/wdata until ack; req is ignored outside IDLE.
// Ports: clk/reset; bus side req/we/addr/wdata -> rdata/ack/fault; rom_*/ram_* synchronous macro side;
//        port_in (async, synchronised), port_out (registered) and one-hot port_wr per I/O channel.
module mem_bus_ctrl #(
  parameter int DW          = 8,
  parameter int AW          = 8,
  parameter int ROM_BASE    = 'h00,
  parameter int ROM_SIZE    = 128,
  parameter int RAM_BASE    = 'h80,
  parameter int RAM_SIZE    = 96,
  parameter int IO_BASE     = 'hF0,
  parameter int N_PORTS     = 16,
  parameter int WAIT_STATES = 1,
  localparam int ROM_AW     = (ROM_SIZE > 1) ? $clog2(ROM_SIZE) : 1,
  localparam int RAM_AW     = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DW-1:0]         wdata,
  output logic [DW-1:0]         rdata,
  output logic                  ack,
  output logic                  fault,
  output logic [ROM_AW-1:0]     rom_addr,
  input  logic [DW-1:0]         rom_rdata,
  output logic [RAM_AW-1:0]     ram_addr,
  output logic [DW-1:0]         ram_wdata,
  output logic                  ram_we,
  input  logic [DW-1:0]         ram_rdata,
  input  logic [N_PORTS*DW-1:0] port_in,
  output logic [N_PORTS*DW-1:0] port_out,
  output logic [N_PORTS-1:0]    port_wr
);
  localparam int IO_AW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {RGN_ROM, RGN_RAM, RGN_IO, RGN_NONE} region_t;

  state_t state, state_nxt;

  // Decode in AW+1 bits. An address below a base wraps to >= 2**AW, which is
  // never below a region size, so a single unsigned compare per region checks
  // both bounds, and base+size may reach 2**AW without wrapping to zero.
  logic [AW:0] addr_x, rom_off_x, ram_off_x, io_off_x;
  logic        in_rom, in_ram, in_io;
  region_t     dec_region;

  assign addr_x    = {1'b0, addr};
  assign rom_off_x = addr_x - (AW+1)'(ROM_BASE);
  assign ram_off_x = addr_x - (AW+1)'(RAM_BASE);
  assign io_off_x  = addr_x - (AW+1)'(IO_BASE);
  assign in_rom    = rom_off_x < (AW+1)'(ROM_SIZE);
  assign in_ram    = ram_off_x < (AW+1)'(RAM_SIZE);
  assign in_io     = io_off_x  < (AW+1)'(N_PORTS);

  always_comb begin
    if (in_rom)      dec_region = RGN_ROM;
    else if (in_ram) dec_region = RGN_RAM;
    else if (in_io)  dec_region = RGN_IO;
    else             dec_region = RGN_NONE;
  end

  // Request captured in IDLE
  logic                  we_q;
  region_t               region_q;
  logic [DW-1:0]         wdata_q;
  logic [IO_AW-1:0]      io_idx_q;
  logic [2:0]            cnt;
  logic [ROM_AW-1:0]     rom_addr_q;
  logic [RAM_AW-1:0]     ram_addr_q;
  logic [N_PORTS*DW-1:0] sync1, sync2;

  logic               start, resp_entry, acc_fault, io_write;
  logic [N_PORTS-1:0] io_onehot;
  logic [DW-1:0]      io_rdata;

  assign start      = (state == IDLE) && req;
  assign resp_entry = (state == ACCESS) && (cnt == 3'd0);
  assign acc_fault  = (region_q == RGN_NONE) || ((region_q == RGN_ROM) && we_q);
  assign io_write   = (region_q == RGN_IO) && we_q;

  // The macros register their address at the clock edge, so the decoded
  // offset is passed straight through in the request cycle; read data is then
  // back by the first ACCESS edge, which WAIT_STATES=1 relies on.
  assign rom_addr = (start && (dec_region == RGN_ROM) && !we) ? rom_off_x[ROM_AW-1:0] : rom_addr_q;
  assign ram_addr = (start && (dec_region == RGN_RAM)) ? ram_off_x[RAM_AW-1:0] : ram_addr_q;

  always_comb begin
    io_onehot           = '0;
    io_onehot[io_idx_q] = 1'b1;
  end

  always_comb begin
    io_rdata = '0;
    for (int k = 0; k < N_PORTS; k++)
      if (io_onehot[k]) io_rdata = sync2[k*DW +: DW];
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = ACCESS;
      ACCESS:  if (cnt == 3'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ack     = 1'b0;
    fault   = 1'b0;
    port_wr = '0;
    if (state == RESP) begin
      ack   = 1'b1;
      fault = acc_fault;
      if (io_write) port_wr = io_onehot;
    end
  end

  // Datapath: capture, wait counter, macro strobes, read data, output ports
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q       <= 1'b0;
      region_q   <= RGN_NONE;
      wdata_q    <= '0;
      io_idx_q   <= '0;
      cnt        <= '0;
      rom_addr_q <= '0;
      ram_addr_q <= '0;
      ram_wdata  <= '0;
      ram_we     <= 1'b0;
      rdata      <= '0;
      port_out   <= '0;
      sync1      <= '0;
      sync2      <= '0;
    end else begin
      sync1  <= port_in;
      sync2  <= sync1;
      ram_we <= 1'b0;
      if (start) begin
        we_q     <= we;
        region_q <= dec_region;
        wdata_q  <= wdata;
        io_idx_q <= io_off_x[IO_AW-1:0];
        cnt      <= 3'(WAIT_STATES - 1);
        if ((dec_region == RGN_ROM) && !we) rom_addr_q <= rom_off_x[ROM_AW-1:0];
        if (dec_region == RGN_RAM) begin
          ram_addr_q <= ram_off_x[RAM_AW-1:0];
          ram_wdata  <= wdata;
          ram_we     <= we;   // high for exactly the first ACCESS cycle
        end
      end else if ((state == ACCESS) && (cnt != 3'd0)) begin
        cnt <= cnt - 3'd1;
      end
      if (resp_entry) begin
        if (acc_fault) begin
          rdata <= '0;
        end else if (!we_q) begin
          case (region_q)
            RGN_ROM: rdata <= rom_rdata;
            RGN_RAM: rdata <= ram_rdata;
            RGN_IO:  rdata <= io_rdata;
            default: rdata <= '0;
          endcase
        end
        for (int k = 0; k < N_PORTS; k++)
          if (io_write && io_onehot[k]) port_out[k*DW +: DW] <= wdata_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Testbench for mem_bus_ctrl: instance 0 uses default parameters, instance 1
// uses N_PORTS=4 / WAIT_STATES=3. ROM/RAM macros are modelled as registered
// reads; expected results come from an address-map reference model.
module tb_mem_bus_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance 0 (defaults)
  logic         req1, we1, ack1, fault1, ram_we1;
  logic [7:0]   addr1, wdata1, rdata1, rom_rdata1, ram_rdata1, ram_wdata1;
  logic [6:0]   rom_addr1, ram_addr1;
  logic [127:0] port_in1, port_out1;
  logic [15:0]  port_wr1;
  // Instance 1 (4 ports, 3 wait states)
  logic         req2, we2, ack2, fault2, ram_we2;
  logic [7:0]   addr2, wdata2, rdata2, rom_rdata2, ram_rdata2, ram_wdata2;
  logic [6:0]   rom_addr2, ram_addr2;
  logic [31:0]  port_in2, port_out2;
  logic [3:0]   port_wr2;

  mem_bus_ctrl u_dut1 (
    .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .ack(ack1), .fault(fault1), .rom_addr(rom_addr1), .rom_rdata(rom_rdata1),
    .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_we(ram_we1), .ram_rdata(ram_rdata1),
    .port_in(port_in1), .port_out(port_out1), .port_wr(port_wr1));

  mem_bus_ctrl #(.N_PORTS(4), .WAIT_STATES(3)) u_dut2 (
    .clk(clk), .reset(reset), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
    .rdata(rdata2), .ack(ack2), .fault(fault2), .rom_addr(rom_addr2), .rom_rdata(rom_rdata2),
    .ram_addr(ram_addr2), .ram_wdata(ram_wdata2), .ram_we(ram_we2), .ram_rdata(ram_rdata2),
    .port_in(port_in2), .port_out(port_out2), .port_wr(port_wr2));

  // Synchronous memory macros
  logic [7:0] rom_mem  [128];
  logic [7:0] ram_mem1 [96] = '{default: 8'h00};
  logic [7:0] ram_mem2 [96] = '{default: 8'h00};
  always @(posedge clk) begin
    rom_rdata1 <= rom_mem[rom_addr1];
    rom_rdata2 <= rom_mem[rom_addr2];
    ram_rdata1 <= ram_mem1[ram_addr1];
    ram_rdata2 <= ram_mem2[ram_addr2];
    if (ram_we1) ram_mem1[ram_addr1] <= ram_wdata1;
    if (ram_we2) ram_mem2[ram_addr2] <= ram_wdata2;
  end

  // Event monitors
  int         ack_cnt2 = 0, ram_we_cnt1 = 0, ram_we_cnt2 = 0, port_wr_cnt1 = 0;
  logic [6:0] ram_addr_seen1 = '0;
  always @(negedge clk) begin
    if (ack2) ack_cnt2 <= ack_cnt2 + 1;
    if (ram_we2) ram_we_cnt2 <= ram_we_cnt2 + 1;
    if (ram_we1) begin
      ram_we_cnt1    <= ram_we_cnt1 + 1;
      ram_addr_seen1 <= ram_addr1;
    end
    if (port_wr1 != '0) port_wr_cnt1 <= port_wr_cnt1 + 1;
  end

  // Reference model: memory map as plain address ranges
  logic [7:0] m_ram  [2][96];
  logic [7:0] m_port [2][16];

  function automatic void model(input int s, input bit w, input logic [7:0] a,
                                input logic [7:0] d, output logic [7:0] erd, output bit eflt);
    int ai, np;
    ai   = int'(a);
    np   = (s == 0) ? 16 : 4;
    erd  = 8'h00;
    eflt = 1'b0;
    if (ai < 128) begin
      if (w) eflt = 1'b1;
      else   erd  = rom_mem[ai];
    end else if (ai < 128 + 96) begin
      if (w) m_ram[s][ai-128] = d;
      else   erd = m_ram[s][ai-128];
    end else if (ai >= 240 && ai < 240 + np) begin
      if (w)           m_port[s][ai-240] = d;
      else if (s == 0) erd = port_in1[(ai-240)*8 +: 8];
      else             erd = port_in2[(ai-240)*8 +: 8];
    end else begin
      eflt = 1'b1;
    end
  endfunction

  function automatic logic [127:0] exp_ports1();
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = m_port[0][k];
    return r;
  endfunction

  function automatic logic [31:0] exp_ports2();
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[k*8 +: 8] = m_port[1][k];
    return r;
  endfunction

  task automatic drive(input int s, input bit r, input bit w, input logic [7:0] a, input logic [7:0] d);
    if (s == 0) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    else        begin req2 = r; we2 = w; addr2 = a; wdata2 = d; end
  endtask

  // One access: waits one edge so the FSM is back in IDLE, raises req, returns
  // at #1 into the ack cycle. lat = edges from req to ack, -1 on timeout.
  task automatic access(input int s, input bit w, input logic [7:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output logic flt, output int lat, output logic [15:0] pwr);
    lat = -1; rd = '0; flt = 1'b0; pwr = '0;
    @(posedge clk); #1;
    drive(s, 1'b1, w, a, d);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if ((s == 0) ? ack1 : ack2) begin
        lat = c;
        rd  = (s == 0) ? rdata1 : rdata2;
        flt = (s == 0) ? fault1 : fault2;
        pwr = (s == 0) ? port_wr1 : {12'h000, port_wr2};
        break;
      end
    end
    drive(s, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_reset();
    logic [7:0] rd; logic flt; int lat; logic [15:0] pwr; int a0;
    checks++;
    if ({ack1, fault1, rdata1, ram_we1, rom_addr1, ram_addr1, ram_wdata1, port_wr1} !== '0 || port_out1 !== '0) begin
      failures++;
      $display("FAIL reset_values: ack=%b fault=%b rdata=%h ram_we=%b rom_addr=%h ram_addr=%h ram_wdata=%h port_wr=%h port_out=%h, all must be 0",
               ack1, fault1, rdata1, ram_we1, rom_addr1, ram_addr1, ram_wdata1, port_wr1, port_out1);
    end
    @(posedge clk); #1 reset = 1'b1;
    a0 = ack_cnt2;
    drive(1, 1'b1, 1'b1, 8'h90, 8'h9A);
    @(posedge clk); #1;          // request taken, ram_we strobing
    @(posedge clk); #1;          // RAM write has landed; still mid-ACCESS
    reset = 1'b0;
    m_ram[1][16] = 8'h9A;
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ack_cnt2 != a0) begin
      failures++; $display("FAIL reset_abort_ack: %0d acks during aborted access, required 0", ack_cnt2 - a0);
    end
    checks++;
    if ({ack2, fault2, rdata2, ram_we2, rom_addr2, ram_addr2, ram_wdata2, port_wr2} !== '0 || port_out2 !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: ack=%b fault=%b rdata=%h ram_we=%b rom_addr=%h ram_addr=%h ram_wdata=%h port_wr=%h port_out=%h, all must be 0",
               ack2, fault2, rdata2, ram_we2, rom_addr2, ram_addr2, ram_wdata2, port_wr2, port_out2);
    end
    reset = 1'b1;
    access(1, 1'b0, 8'h90, 8'h00, rd, flt, lat, pwr);
    checks++;
    if (lat != 4 || flt !== 1'b0 || rd !== 8'h9A) begin
      failures++; $display("FAIL reset_after_release: lat=%0d fault=%b rdata=%h, required lat=4 fault=0 rdata=9a", lat, flt, rd);
    end
  endtask

  task automatic test_ram_roundtrip();
    logic [7:0] rd, erd; logic flt; bit eflt; int lat; logic [15:0] pwr; int w0;
    w0 = ram_we_cnt1;
    model(0, 1'b1, 8'h85, 8'hA5, erd, eflt);
    access(0, 1'b1, 8'h85, 8'hA5, rd, flt, lat, pwr);
    checks++;
    if (lat != 2 || flt !== 1'b0 || ram_we_cnt1 - w0 != 1 || ram_addr_seen1 !== 7'd5) begin
      failures++;
      $display("FAIL ram_write: lat=%0d fault=%b ram_we_pulses=%0d ram_addr=%h, required lat=2 fault=0 pulses=1 ram_addr=05",
               lat, flt, ram_we_cnt1 - w0, ram_addr_seen1);
    end
    model(0, 1'b0, 8'h85, 8'h00, erd, eflt);
    access(0, 1'b0, 8'h85, 8'h00, rd, flt, lat, pwr);
    checks++;
    if (lat != 2 || flt !== 1'b0 || rd !== 8'hA5) begin
      failures++; $display("FAIL ram_read: lat=%0d fault=%b rdata=%h, required lat=2 fault=0 rdata=a5", lat, flt, rd);
    end
  endtask

  task automatic test_rom();
    logic [7:0] rd; logic flt; int lat; logic [15:0] pwr; int w0;
    access(0, 1'b0, 8'h7F, 8'h00, rd, flt, lat, pwr);
    checks++;
    if (lat != 2 || flt !== 1'b0 || rd !== 8'h3C || rom_addr1 !== 7'h7F) begin
      failures++; $display("FAIL rom_read: lat=%0d fault=%b rdata=%h rom_addr=%h, required 2/0/3c/7f", lat, flt, rd, rom_addr1);
    end
    w0 = ram_we_cnt1;
    access(0, 1'b1, 8'h10, 8'h77, rd, flt, lat, pwr);
    checks++;
    if (lat != 2 || flt !== 1'b1 || rd !== 8'h00 || rom_addr1 !== 7'h7F || pwr !== 16'h0 || ram_we_cnt1 != w0) begin
      failures++;
      $display("FAIL rom_write_fault: lat=%0d fault=%b rdata=%h rom_addr=%h port_wr=%h ram_we_pulses=%0d, required 2/1/00/7f/0000/0",
               lat, flt, rd, rom_addr1, pwr, ram_we_cnt1 - w0);
    end
  endtask

  task automatic test_io();
    logic [7:0] rd, erd; logic flt; bit eflt; int lat; logic [15:0] pwr; int p0;
    p0 = port_wr_cnt1;
    model(0, 1'b1, 8'hF3, 8'h5A, erd, eflt);
    access(0, 1'b1, 8'hF3, 8'h5A, rd, flt, lat, pwr);
    checks++;
    if (lat != 2 || flt !== 1'b0 || pwr !== 16'h0008 || port_out1 !== exp_ports1()) begin
      failures++; $display("FAIL io_write: lat=%0d fault=%b port_wr=%h port_out=%h, required 2/0/0008/%h", lat, flt, pwr, port_out1, exp_ports1());
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (port_wr_cnt1 - p0 != 1 || port_wr1 !== 16'h0) begin
      failures++; $display("FAIL io_wr_pulse: pulses=%0d port_wr=%h, required 1 pulse then 0000", port_wr_cnt1 - p0, port_wr1);
    end
    port_in1[31:24] = 8'hC3;
    repeat (2) @(posedge clk);
    access(0, 1'b0, 8'hF3, 8'h00, rd, flt, lat, pwr);
    checks++;
    if (lat != 2 || flt !== 1'b0 || rd !== 8'hC3) begin
      failures++; $display("FAIL io_read: lat=%0d fault=%b rdata=%h, required 2/0/c3", lat, flt, rd);
    end
    // Top of the address space: channel 15 at 'hFF, no wrap
    port_in1[127:120] = 8'h6D;
    repeat (2) @(posedge clk);
    access(0, 1'b0, 8'hFF, 8'h00, rd, flt, lat, pwr);
    checks++;
    if (flt !== 1'b0 || rd !== 8'h6D) begin
      failures++; $display("FAIL io_top_addr: fault=%b rdata=%h, required 0/6d", flt, rd);
    end
  endtask

  task automatic test_unmapped();
    logic [7:0] rd; logic flt; int lat; logic [15:0] pwr; logic [31:0] po;
    access(0, 1'b0, 8'hE5, 8'h00, rd, flt, lat, pwr);
    checks++;
    if (lat != 2 || flt !== 1'b1 || rd !== 8'h00) begin
      failures++; $display("FAIL unmapped_e5: lat=%0d fault=%b rdata=%h, required 2/1/00", lat, flt, rd);
    end
    access(0, 1'b0, 8'hE0, 8'h00, rd, flt, lat, pwr);
    checks++;
    if (flt !== 1'b1 || rd !== 8'h00) begin
      failures++; $display("FAIL unmapped_ram_end: fault=%b rdata=%h, required 1/00", flt, rd);
    end
    po = port_out2;
    access(1, 1'b0, 8'hF7, 8'h00, rd, flt, lat, pwr);
    checks++;
    if (lat != 4 || flt !== 1'b1 || rd !== 8'h00) begin
      failures++; $display("FAIL unmapped_f7_read: lat=%0d fault=%b rdata=%h, required 4/1/00", lat, flt, rd);
    end
    access(1, 1'b1, 8'hF7, 8'hEE, rd, flt, lat, pwr);
    checks++;
    if (flt !== 1'b1 || rd !== 8'h00 || pwr !== 16'h0 || port_out2 !== po) begin
      failures++; $display("FAIL unmapped_f7_write: fault=%b rdata=%h port_wr=%h port_out=%h, required 1/00/0000/%h", flt, rd, pwr, port_out2, po);
    end
  endtask

  task automatic test_random();
    logic [7:0] rd, erd, a, d; logic flt; bit eflt, w; int lat; logic [15:0] pwr;
    logic [7:0] edges [8] = '{8'h00, 8'h7F, 8'h80, 8'hDF, 8'hE0, 8'hEF, 8'hF0, 8'hFF};
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 1) == 0) ? edges[$urandom_range(0, 7)] : 8'($urandom_range(0, 255));
      w = 1'($urandom_range(0, 1));
      d = 8'($urandom_range(0, 255));
      if (i % 8 == 0) port_in1 = {$urandom, $urandom, $urandom, $urandom};
      repeat (2) @(posedge clk);
      model(0, w, a, d, erd, eflt);
      access(0, w, a, d, rd, flt, lat, pwr);
      checks++;
      if (lat != 2 || flt !== eflt || ((!w || eflt) && rd !== erd) || port_out1 !== exp_ports1()) begin
        failures++;
        $display("FAIL random[%0d] we=%b addr=%h: lat=%0d fault=%b rdata=%h port_out=%h, required lat=2 fault=%b rdata=%h port_out=%h",
                 i, w, a, lat, flt, rd, port_out1, eflt, erd, exp_ports1());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] erd, a, d; bit eflt, w; int last, n, a0;
    a0 = ack_cnt2; last = 0; n = 0;
    a = 8'($urandom_range(0, 255)); w = 1'($urandom_range(0, 1)); d = 8'($urandom_range(0, 255));
    model(1, w, a, d, erd, eflt);
    @(posedge clk); #1;
    drive(1, 1'b1, w, a, d);
    for (int c = 1; c <= 120 && n < 12; c++) begin
      @(posedge clk); #1;
      if (ack2) begin
        checks++;
        if ((c - last) != ((n == 0) ? 4 : 5) || fault2 !== eflt || ((!w || eflt) && rdata2 !== erd) || port_out2 !== exp_ports2()) begin
          failures++;
          $display("FAIL b2b[%0d] we=%b addr=%h: gap=%0d fault=%b rdata=%h port_out=%h, required gap=%0d fault=%b rdata=%h port_out=%h",
                   n, w, a, c - last, fault2, rdata2, port_out2, (n == 0) ? 4 : 5, eflt, erd, exp_ports2());
        end
        last = c;
        n++;
        if (n < 12) begin
          a = 8'($urandom_range(0, 255)); w = 1'($urandom_range(0, 1)); d = 8'($urandom_range(0, 255));
          model(1, w, a, d, erd, eflt);
          drive(1, 1'b1, w, a, d);
        end
      end
    end
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (n != 12 || ack_cnt2 - a0 != 12) begin
      failures++; $display("FAIL b2b_count: acks seen=%0d monitor=%0d, required 12", n, ack_cnt2 - a0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 128; i++) rom_mem[i] = 8'($urandom);
    rom_mem[127] = 8'h3C;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 96; i++) m_ram[s][i] = 8'h00;
      for (int i = 0; i < 16; i++) m_port[s][i] = 8'h00;
    end
    port_in1 = {$urandom, $urandom, $urandom, $urandom};
    port_in2 = $urandom;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_ram_roundtrip();
    test_rom();
    test_io();
    test_unmapped();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
